// File: rtl/phrase_feature_extractor.sv
// Scans a frozen 16-note phrase oldest-to-newest, one note per cycle, accumulating
// interval/rest/pitch statistics and latching a 2-bit emotion class.
module phrase_feature_extractor #(
  parameter logic [9:0] LEAP_THRESH = 10'd120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] n0,
  input  logic [5:0] n1,
  input  logic [5:0] n2,
  input  logic [5:0] n3,
  input  logic [5:0] n4,
  input  logic [5:0] n5,
  input  logic [5:0] n6,
  input  logic [5:0] n7,
  input  logic [5:0] n8,
  input  logic [5:0] n9,
  input  logic [5:0] n10,
  input  logic [5:0] n11,
  input  logic [5:0] n12,
  input  logic [5:0] n13,
  input  logic [5:0] n14,
  input  logic [5:0] n15,
  input  logic       buffer_full,
  output logic       busy,
  output logic       done,
  output logic       valid,
  output logic [3:0] up_count,
  output logic [3:0] down_count,
  output logic [3:0] repeat_count,
  output logic [4:0] rest_count,
  output logic [5:0] pitch_min,
  output logic [5:0] pitch_max,
  output logic [5:0] pitch_range,
  output logic [9:0] abs_sum,
  output logic [1:0] emotion
);

  typedef enum logic [1:0] {StIdle, StScan, StClassify, StHold} state_e;

  state_e r_state, w_state_next;

  logic [5:0] w_notes [16];
  logic [5:0] w_note;
  logic       w_is_rest, w_is_up, w_is_down;
  logic [5:0] w_diff;
  logic [1:0] w_emotion;

  // Scan accumulators
  logic [3:0] r_idx;
  logic [5:0] r_prev;
  logic       r_have_prev;
  logic [3:0] r_acc_up, r_acc_down, r_acc_rep;
  logic [4:0] r_acc_rest;
  logic [5:0] r_acc_min, r_acc_max;
  logic [9:0] r_acc_sum;

  // Latched results
  logic       r_done, r_valid;
  logic [3:0] r_up, r_down, r_rep;
  logic [4:0] r_rest;
  logic [5:0] r_min, r_max, r_range;
  logic [9:0] r_sum;
  logic [1:0] r_emotion;

  assign w_notes[0]  = n0;
  assign w_notes[1]  = n1;
  assign w_notes[2]  = n2;
  assign w_notes[3]  = n3;
  assign w_notes[4]  = n4;
  assign w_notes[5]  = n5;
  assign w_notes[6]  = n6;
  assign w_notes[7]  = n7;
  assign w_notes[8]  = n8;
  assign w_notes[9]  = n9;
  assign w_notes[10] = n10;
  assign w_notes[11] = n11;
  assign w_notes[12] = n12;
  assign w_notes[13] = n13;
  assign w_notes[14] = n14;
  assign w_notes[15] = n15;

  assign w_note    = w_notes[r_idx];
  assign w_is_rest = (w_note == 6'd0);
  assign w_is_up   = (w_note > r_prev);
  assign w_is_down = (w_note < r_prev);
  assign w_diff    = w_is_up ? (w_note - r_prev) : (r_prev - w_note);

  always_comb begin
    w_emotion = 2'd0;
    if (r_acc_sum >= LEAP_THRESH)     w_emotion = 2'd3;
    else if (r_acc_up > r_acc_down)   w_emotion = 2'd1;
    else if (r_acc_down > r_acc_up)   w_emotion = 2'd2;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:     if (buffer_full) w_state_next = StScan;
      StScan: begin
        if (!buffer_full)       w_state_next = StIdle;
        else if (r_idx == 4'd0) w_state_next = StClassify;
      end
      StClassify: w_state_next = buffer_full ? StHold : StIdle;
      StHold:     if (!buffer_full) w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx       <= 4'd0;
      r_prev      <= 6'd0;
      r_have_prev <= 1'b0;
      r_acc_up    <= 4'd0;
      r_acc_down  <= 4'd0;
      r_acc_rep   <= 4'd0;
      r_acc_rest  <= 5'd0;
      r_acc_min   <= 6'd0;
      r_acc_max   <= 6'd0;
      r_acc_sum   <= 10'd0;
      r_done      <= 1'b0;
      r_valid     <= 1'b0;
      r_up        <= 4'd0;
      r_down      <= 4'd0;
      r_rep       <= 4'd0;
      r_rest      <= 5'd0;
      r_min       <= 6'd0;
      r_max       <= 6'd0;
      r_range     <= 6'd0;
      r_sum       <= 10'd0;
      r_emotion   <= 2'd0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (buffer_full) begin
            r_idx       <= 4'd15;
            r_have_prev <= 1'b0;
            r_acc_up    <= 4'd0;
            r_acc_down  <= 4'd0;
            r_acc_rep   <= 4'd0;
            r_acc_rest  <= 5'd0;
            r_acc_min   <= 6'd63;
            r_acc_max   <= 6'd0;
            r_acc_sum   <= 10'd0;
            r_valid     <= 1'b0;
          end
        end
        StScan: begin
          if (buffer_full) begin
            r_idx <= r_idx - 4'd1;
            if (w_is_rest) begin
              r_acc_rest <= r_acc_rest + 5'd1;
            end else begin
              if (w_note < r_acc_min) r_acc_min <= w_note;
              if (w_note > r_acc_max) r_acc_max <= w_note;
              if (r_have_prev) begin
                if (w_is_up)        r_acc_up   <= r_acc_up + 4'd1;
                else if (w_is_down) r_acc_down <= r_acc_down + 4'd1;
                else                r_acc_rep  <= r_acc_rep + 4'd1;
                r_acc_sum <= r_acc_sum + {4'd0, w_diff};
              end
              r_prev      <= w_note;
              r_have_prev <= 1'b1;
            end
          end
        end
        StClassify: begin
          // An abort here leaves the previous results in place with valid low
          if (buffer_full) begin
            r_up      <= r_acc_up;
            r_down    <= r_acc_down;
            r_rep     <= r_acc_rep;
            r_rest    <= r_acc_rest;
            r_min     <= r_have_prev ? r_acc_min : 6'd0;
            r_max     <= r_have_prev ? r_acc_max : 6'd0;
            r_range   <= r_have_prev ? (r_acc_max - r_acc_min) : 6'd0;
            r_sum     <= r_acc_sum;
            r_emotion <= w_emotion;
            r_valid   <= 1'b1;
            r_done    <= 1'b1;
          end
        end
        StHold: ;
        default: ;
      endcase
    end
  end

  assign busy         = (r_state == StScan) || (r_state == StClassify);
  assign done         = r_done;
  assign valid        = r_valid;
  assign up_count     = r_up;
  assign down_count   = r_down;
  assign repeat_count = r_rep;
  assign rest_count   = r_rest;
  assign pitch_min    = r_min;
  assign pitch_max    = r_max;
  assign pitch_range  = r_range;
  assign abs_sum      = r_sum;
  assign emotion      = r_emotion;

endmodule

// File: tb/tb_phrase_feature_extractor.sv
// Directed bench for phrase_feature_extractor: feature vectors, latency, abort, reset, hold.
module tb_phrase_feature_extractor;

  logic       clk = 1'b0;
  logic       reset;
  logic       buffer_full;
  logic [5:0] nt [16];
  logic       busy, done, valid;
  logic [3:0] up_count, down_count, repeat_count;
  logic [4:0] rest_count;
  logic [5:0] pitch_min, pitch_max, pitch_range;
  logic [9:0] abs_sum;
  logic [1:0] emotion;

  int n_cmp = 0;
  int n_err = 0;
  int done_pulses = 0;
  int dp;

  phrase_feature_extractor #(.LEAP_THRESH(10'd120)) dut (
    .clk(clk), .reset(reset),
    .n0(nt[0]), .n1(nt[1]), .n2(nt[2]), .n3(nt[3]),
    .n4(nt[4]), .n5(nt[5]), .n6(nt[6]), .n7(nt[7]),
    .n8(nt[8]), .n9(nt[9]), .n10(nt[10]), .n11(nt[11]),
    .n12(nt[12]), .n13(nt[13]), .n14(nt[14]), .n15(nt[15]),
    .buffer_full(buffer_full),
    .busy(busy), .done(done), .valid(valid),
    .up_count(up_count), .down_count(down_count), .repeat_count(repeat_count),
    .rest_count(rest_count), .pitch_min(pitch_min), .pitch_max(pitch_max),
    .pitch_range(pitch_range), .abs_sum(abs_sum), .emotion(emotion)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Raise buffer_full, check busy after E0 and that done arrives 17 edges later.
  task automatic run_scan(input string tag);
    int lat;
    @(negedge clk);
    buffer_full = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_busy"}, busy, 1);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done === 1'b1) break;
    end
    check({tag, "_latency"}, lat, 17);
    check({tag, "_valid"}, valid, 1);
  endtask

  task automatic release_full();
    @(negedge clk);
    buffer_full = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic set_ascending();
    for (int i = 0; i < 16; i++) nt[i] = 6'(16 - i);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_up"}, up_count, 0);
    check({tag, "_rest"}, rest_count, 0);
    check({tag, "_max"}, pitch_max, 0);
    check({tag, "_range"}, pitch_range, 0);
    check({tag, "_sum"}, abs_sum, 0);
    check({tag, "_emo"}, emotion, 0);
  endtask

  initial begin
    reset = 1'b1;
    buffer_full = 1'b0;
    for (int i = 0; i < 16; i++) nt[i] = 6'd0;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    reset = 1'b0;
    @(negedge clk);

    // Ascending 1..16 from oldest
    set_ascending();
    run_scan("asc");
    check("asc_up", up_count, 15);
    check("asc_down", down_count, 0);
    check("asc_rep", repeat_count, 0);
    check("asc_rest", rest_count, 0);
    check("asc_min", pitch_min, 1);
    check("asc_max", pitch_max, 16);
    check("asc_range", pitch_range, 15);
    check("asc_sum", abs_sum, 15);
    check("asc_emo", emotion, 1);
    @(negedge clk);
    check("asc_done_one_cycle", done, 0);
    check("asc_busy_hold", busy, 0);
    release_full();
    check("asc_valid_idle", valid, 1);
    check("asc_up_idle", up_count, 15);

    // Reset at E5 mid-scan
    @(negedge clk);
    buffer_full = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("rst_e5");
    reset = 1'b0;
    buffer_full = 1'b0;
    repeat (2) @(negedge clk);

    // Descending 40..25 from oldest
    for (int i = 0; i < 16; i++) nt[i] = 6'(25 + i);
    run_scan("desc");
    check("desc_up", up_count, 0);
    check("desc_down", down_count, 15);
    check("desc_min", pitch_min, 25);
    check("desc_range", pitch_range, 15);
    check("desc_sum", abs_sum, 15);
    check("desc_emo", emotion, 2);
    release_full();

    // Alternating 10,50 starting at n15: agitated beats happy
    for (int i = 0; i < 16; i++) nt[i] = (i % 2 == 1) ? 6'd10 : 6'd50;
    run_scan("alt");
    check("alt_up", up_count, 8);
    check("alt_down", down_count, 7);
    check("alt_sum", abs_sum, 600);
    check("alt_range", pitch_range, 40);
    check("alt_min", pitch_min, 10);
    check("alt_emo", emotion, 3);
    release_full();

    // All rests
    for (int i = 0; i < 16; i++) nt[i] = 6'd0;
    run_scan("rest");
    check("rest_rest", rest_count, 16);
    check("rest_up", up_count, 0);
    check("rest_rep", repeat_count, 0);
    check("rest_min", pitch_min, 0);
    check("rest_max", pitch_max, 0);
    check("rest_range", pitch_range, 0);
    check("rest_sum", abs_sum, 0);
    check("rest_emo", emotion, 0);
    release_full();

    // 20,0 repeated from n15: intervals bridge the rests
    for (int i = 0; i < 16; i++) nt[i] = (i % 2 == 1) ? 6'd20 : 6'd0;
    run_scan("pr");
    check("pr_rest", rest_count, 8);
    check("pr_rep", repeat_count, 7);
    check("pr_up", up_count, 0);
    check("pr_down", down_count, 0);
    check("pr_min", pitch_min, 20);
    check("pr_max", pitch_max, 20);
    check("pr_sum", abs_sum, 0);
    check("pr_emo", emotion, 0);
    release_full();

    // Abort: buffer_full sampled low at E8
    set_ascending();
    @(negedge clk);
    buffer_full = 1'b1;
    @(posedge clk);
    repeat (7) @(posedge clk);
    @(negedge clk);
    buffer_full = 1'b0;
    dp = done_pulses;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    check("abort_done", done, 0);
    check("abort_rest_kept", rest_count, 8);
    check("abort_rep_kept", repeat_count, 7);
    repeat (25) @(negedge clk);
    check("abort_no_done", done_pulses - dp, 0);

    // Full held 100 cycles past done: exactly one pulse
    dp = done_pulses;
    run_scan("hold");
    check("hold_up", up_count, 15);
    repeat (100) @(negedge clk);
    check("hold_one_done", done_pulses - dp, 1);
    check("hold_busy", busy, 0);
    check("hold_valid", valid, 1);
    release_full();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
